// File: rtl/biquad_engine.sv
// biquad_engine: runs one Direct-Form-I biquad section per accepted sample for two
// interleaved channels. Coefficients and per-channel delay state live in an external
// 16-entry dual-port RAM with registered reads; this block is that RAM's only master.
// It also handles coefficient writes and clearing of the delay state.
//
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   in_valid/in_ready/in_ch/in_sample    sample input handshake
//   out_valid/out_ch/out_sample          one-cycle result strobe
//   cfg_we/cfg_addr/cfg_data/cfg_ready   RAM word write (coefficients)
//   clr_req/clr_busy                     zero all channel delay state
//   ram_addr_*/ram_d_*/ram_we_*/ram_q_*  dual-port RAM master (1-cycle read latency)
//
// RAM map: 0 B0, 1 B1, 2 B2, 3 A1, 4 A2; channel base S = 5 + 4*ch holds X1, X2, Y1, Y2.
module biquad_engine #(
   parameter int unsigned NBITS = 32,
   parameter int unsigned FRAC  = 30
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_ch,
   input  logic [NBITS-1:0] in_sample,
   output logic             out_valid,
   output logic             out_ch,
   output logic [NBITS-1:0] out_sample,
   input  logic             cfg_we,
   input  logic [3:0]       cfg_addr,
   input  logic [NBITS-1:0] cfg_data,
   output logic             cfg_ready,
   input  logic             clr_req,
   output logic             clr_busy,
   output logic [3:0]       ram_addr_a,
   output logic [3:0]       ram_addr_b,
   output logic [NBITS-1:0] ram_d_a,
   output logic [NBITS-1:0] ram_d_b,
   output logic             ram_we_a,
   output logic             ram_we_b,
   input  logic [NBITS-1:0] ram_q_a,
   input  logic [NBITS-1:0] ram_q_b
);

   localparam int unsigned AccW = 2 * NBITS + 3;

   localparam logic [3:0] AddrB0 = 4'd0;
   localparam logic [3:0] AddrB1 = 4'd1;
   localparam logic [3:0] AddrB2 = 4'd2;
   localparam logic [3:0] AddrA1 = 4'd3;
   localparam logic [3:0] AddrA2 = 4'd4;

   localparam logic signed [AccW-1:0] RndHalf = {{(AccW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
   localparam logic signed [AccW-1:0] SatMax  = {{(AccW-NBITS+1){1'b0}}, {(NBITS-1){1'b1}}};
   localparam logic signed [AccW-1:0] SatMin  = {{(AccW-NBITS+1){1'b1}}, {(NBITS-1){1'b0}}};

   // Cycle 1 of a sample sequence is the accept cycle itself (spent in StIdle).
   typedef enum logic [3:0] {
      StIdle, StC2, StC3, StC4, StC5, StC6, StC7, StC8, StClr
   } state_e;

   state_e                  state_q, state_d;
   logic [1:0]              clr_cnt_q;
   logic                    ch_q;
   logic signed [NBITS-1:0] x_q, x1_q, x2_q, y1_q, y2_q, y_q;
   logic signed [AccW-1:0]  acc_q;
   logic                    out_valid_q, out_ch_q;
   logic [NBITS-1:0]        out_sample_q;

   logic       idle, cfg_fire, accept;
   logic [3:0] base_in, base_q;

   assign idle      = (state_q == StIdle);
   assign cfg_ready = idle && !clr_req;
   assign in_ready  = cfg_ready && !cfg_we;
   assign cfg_fire  = cfg_we && cfg_ready;
   assign accept    = in_valid && in_ready;
   assign base_in   = in_ch ? 4'd9 : 4'd5;
   assign base_q    = ch_q ? 4'd9 : 4'd5;

   assign clr_busy   = (state_q == StClr);
   assign out_valid  = out_valid_q;
   assign out_ch     = out_ch_q;
   assign out_sample = out_sample_q;

   // Single shared multiplier: coefficient always arrives on port A.
   logic signed [NBITS-1:0]   coef, mul_op;
   logic signed [2*NBITS-1:0] prod;
   logic signed [AccW-1:0]    prod_ext, rnd, shr;
   logic signed [NBITS-1:0]   y_sat;

   assign coef = ram_q_a;

   always_comb begin
      mul_op = x_q;
      unique case (state_q)
         StC3:    mul_op = x1_q;
         StC4:    mul_op = x2_q;
         StC5:    mul_op = y1_q;
         StC6:    mul_op = y2_q;
         default: mul_op = x_q;
      endcase
   end

   assign prod     = coef * mul_op;
   assign prod_ext = AccW'(prod);
   assign rnd      = acc_q + RndHalf;
   assign shr      = rnd >>> FRAC;

   always_comb begin
      if (shr > SatMax) begin
         y_sat = SatMax[NBITS-1:0];
      end else if (shr < SatMin) begin
         y_sat = SatMin[NBITS-1:0];
      end else begin
         y_sat = shr[NBITS-1:0];
      end
   end

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (clr_req) begin
               state_d = StClr;
            end else if (accept) begin
               state_d = StC2;
            end
         end
         StC2:    state_d = StC3;
         StC3:    state_d = StC4;
         StC4:    state_d = StC5;
         StC5:    state_d = StC6;
         StC6:    state_d = StC7;
         StC7:    state_d = StC8;
         StC8:    state_d = StIdle;
         StClr:   if (clr_cnt_q == 2'd3) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // RAM port outputs. Reads are issued one cycle before the data is consumed.
   always_comb begin
      ram_addr_a = AddrB0;
      ram_addr_b = base_q;
      ram_d_a    = '0;
      ram_d_b    = '0;
      ram_we_a   = 1'b0;
      ram_we_b   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cfg_fire) begin
               ram_addr_a = cfg_addr;
               ram_d_a    = cfg_data;
               ram_we_a   = 1'b1;
            end else begin
               ram_addr_a = AddrB0;
               ram_addr_b = base_in;
            end
         end
         StC2: begin
            ram_addr_a = AddrB1;
            ram_addr_b = base_q + 4'd1;
         end
         StC3: begin
            ram_addr_a = AddrB2;
            ram_addr_b = base_q + 4'd2;
         end
         StC4: begin
            ram_addr_a = AddrA1;
            ram_addr_b = base_q + 4'd3;
         end
         StC5:    ram_addr_a = AddrA2;
         StC7: begin
            ram_addr_a = base_q + 4'd1;
            ram_d_a    = x1_q;
            ram_we_a   = 1'b1;
            ram_addr_b = base_q;
            ram_d_b    = x_q;
            ram_we_b   = 1'b1;
         end
         StC8: begin
            ram_addr_a = base_q + 4'd3;
            ram_d_a    = y1_q;
            ram_we_a   = 1'b1;
            ram_addr_b = base_q + 4'd2;
            ram_d_b    = y_q;
            ram_we_b   = 1'b1;
         end
         StClr: begin
            ram_addr_a = 4'd5 + {1'b0, clr_cnt_q, 1'b0};
            ram_addr_b = 4'd6 + {1'b0, clr_cnt_q, 1'b0};
            ram_we_a   = 1'b1;
            ram_we_b   = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         clr_cnt_q    <= '0;
         ch_q         <= 1'b0;
         x_q          <= '0;
         x1_q         <= '0;
         x2_q         <= '0;
         y1_q         <= '0;
         y2_q         <= '0;
         y_q          <= '0;
         acc_q        <= '0;
         out_valid_q  <= 1'b0;
         out_ch_q     <= 1'b0;
         out_sample_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               clr_cnt_q <= '0;
               if (accept) begin
                  x_q  <= in_sample;
                  ch_q <= in_ch;
               end
            end
            StC2: begin
               acc_q <= prod_ext;
               x1_q  <= ram_q_b;
            end
            StC3: begin
               acc_q <= acc_q + prod_ext;
               x2_q  <= ram_q_b;
            end
            StC4: begin
               acc_q <= acc_q + prod_ext;
               y1_q  <= ram_q_b;
            end
            StC5: begin
               acc_q <= acc_q - prod_ext;
               y2_q  <= ram_q_b;
            end
            StC6:    acc_q <= acc_q - prod_ext;
            StC7:    y_q <= y_sat;
            StClr:   clr_cnt_q <= clr_cnt_q + 2'd1;
            default: ;
         endcase
         out_valid_q <= (state_q == StC8);
         if (state_q == StC8) begin
            out_sample_q <= y_q;
            out_ch_q     <= ch_q;
         end
      end
   end

endmodule

// File: tb/tb_biquad_engine.sv
// Self-checking bench for biquad_engine: behavioural dual-port RAM with registered
// reads, a table of directed sample vectors, plus hand-written priority and
// mid-sequence reset sequences.
module tb_biquad_engine;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_ch = 1'b0;
   logic [31:0] in_sample = '0;
   logic        out_valid;
   logic        out_ch;
   logic [31:0] out_sample;
   logic        cfg_we = 1'b0;
   logic [3:0]  cfg_addr = '0;
   logic [31:0] cfg_data = '0;
   logic        cfg_ready;
   logic        clr_req = 1'b0;
   logic        clr_busy;
   logic [3:0]  ram_addr_a, ram_addr_b;
   logic [31:0] ram_d_a, ram_d_b;
   logic        ram_we_a, ram_we_b;
   logic [31:0] ram_q_a, ram_q_b;

   always #5 clk = ~clk;

   biquad_engine #(.NBITS(32), .FRAC(30)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ch      (in_ch),
      .in_sample  (in_sample),
      .out_valid  (out_valid),
      .out_ch     (out_ch),
      .out_sample (out_sample),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .cfg_ready  (cfg_ready),
      .clr_req    (clr_req),
      .clr_busy   (clr_busy),
      .ram_addr_a (ram_addr_a),
      .ram_addr_b (ram_addr_b),
      .ram_d_a    (ram_d_a),
      .ram_d_b    (ram_d_b),
      .ram_we_a   (ram_we_a),
      .ram_we_b   (ram_we_b),
      .ram_q_a    (ram_q_a),
      .ram_q_b    (ram_q_b)
   );

   // RAM model
   logic [31:0] mem [16];
   always @(posedge clk) begin
      if (ram_we_a) mem[ram_addr_a] <= ram_d_a;
      if (ram_we_b) mem[ram_addr_b] <= ram_d_b;
      ram_q_a <= mem[ram_addr_a];
      ram_q_b <= mem[ram_addr_b];
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Both ports must never write the same address in one cycle.
   always @(negedge clk) begin
      if (rstn && ram_we_a && ram_we_b && ram_addr_a == ram_addr_b) begin
         n_fail++;
         $display("FAIL dual_write_collision: addr 0x%0h", ram_addr_a);
      end
   end

   task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
      int n;
      n = 0;
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      #1;
      while (!cfg_ready && n < 50) begin
         @(negedge clk); #1; n++;
      end
      check("cfg_ready_wait", {31'd0, cfg_ready}, 32'd1);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic load_set(input int s);
      logic [31:0] c [5];
      case (s)
         0:       c = '{32'h40000000, 32'h0, 32'h0, 32'h0, 32'h0};
         1:       c = '{32'h40000000, 32'h0, 32'h0, 32'hE0000000, 32'h0};
         2:       c = '{32'h70000000, 32'h0, 32'h0, 32'h0, 32'h0};
         default: c = '{32'h20000000, 32'h40000000, 32'hC0000000, 32'h0, 32'h10000000};
      endcase
      for (int i = 0; i < 5; i++) cfg_write(4'(i), c[i]);
   endtask

   task automatic do_clear();
      int n;
      int busy;
      @(negedge clk);
      clr_req = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!clr_busy && n < 50);
      clr_req = 1'b0;
      busy = 0;
      while (clr_busy && busy < 50) begin
         busy++;
         @(posedge clk); #1;
      end
      check("clr_busy_cycles", busy, 32'd4);
   endtask

   task automatic run_sample(input bit ch, input logic [31:0] x, input logic [31:0] exp_y,
                             input string name);
      int n;
      int lat;
      @(negedge clk);
      in_valid = 1'b1; in_ch = ch; in_sample = x;
      #1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk); #1; n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      check({name, "_latency"}, lat, 32'd7);
      check({name, "_y"}, out_sample, exp_y);
      check({name, "_ch"}, {31'd0, out_ch}, {31'd0, ch});
      @(posedge clk); #1;
      check({name, "_strobe"}, {31'd0, out_valid}, 32'd0);
   endtask

   typedef struct {
      bit          clr;
      int          cset;
      bit          ch;
      logic [31:0] x;
      logic [31:0] y;
   } vec_t;

   vec_t vecs [16];

   initial begin
      int cur;
      int busy;
      bit seen;

      vecs[0]  = '{1'b1, 0, 1'b0, 32'd1000,     32'd1000};
      vecs[1]  = '{1'b0, 0, 1'b1, 32'hFFFFFFFB, 32'hFFFFFFFB};
      vecs[2]  = '{1'b1, 1, 1'b0, 32'd1024,     32'd1024};
      vecs[3]  = '{1'b0, 1, 1'b1, 32'd0,        32'd0};
      vecs[4]  = '{1'b0, 1, 1'b0, 32'd0,        32'd512};
      vecs[5]  = '{1'b0, 1, 1'b1, 32'd0,        32'd0};
      vecs[6]  = '{1'b0, 1, 1'b0, 32'd0,        32'd256};
      vecs[7]  = '{1'b0, 2, 1'b0, 32'h7FFF0000, 32'h7FFFFFFF};
      vecs[8]  = '{1'b0, 2, 1'b1, 32'h80010000, 32'h80000000};
      vecs[9]  = '{1'b0, 2, 1'b0, 32'd1000,     32'd1750};
      vecs[10] = '{1'b1, 3, 1'b1, 32'd100,      32'd50};
      vecs[11] = '{1'b0, 3, 1'b1, 32'd200,      32'd200};
      vecs[12] = '{1'b0, 3, 1'b1, 32'd0,        32'd88};
      vecs[13] = '{1'b0, 3, 1'b1, 32'd0,        32'hFFFFFF06};
      vecs[14] = '{1'b0, 3, 1'b1, 32'd0,        32'hFFFFFFEA};
      vecs[15] = '{1'b0, 3, 1'b0, 32'd0,        32'd0};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid",  {31'd0, out_valid}, 32'd0);
      check("rst_out_ch",     {31'd0, out_ch},    32'd0);
      check("rst_out_sample", out_sample,         32'd0);
      check("rst_clr_busy",   {31'd0, clr_busy},  32'd0);
      check("rst_we",         {30'd0, ram_we_a, ram_we_b}, 32'd0);
      check("rst_in_ready",   {31'd0, in_ready},  32'd1);
      rstn = 1'b1;

      // Table vectors
      cur = -1;
      for (int i = 0; i < 16; i++) begin
         if (vecs[i].cset != cur) begin
            load_set(vecs[i].cset);
            cur = vecs[i].cset;
         end
         if (vecs[i].clr) do_clear();
         run_sample(vecs[i].ch, vecs[i].x, vecs[i].y, $sformatf("vec%0d", i));
      end

      // Priority: clear beats cfg write beats sample
      for (int i = 5; i <= 13; i++) cfg_write(4'(i), 32'hDEAD0000 | 32'(i));
      load_set(0);
      @(negedge clk);
      clr_req = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd13; cfg_data = 32'h12345678;
      in_valid = 1'b1; in_ch = 1'b0; in_sample = 32'd77;
      #1;
      check("prio_in_ready_0",  {31'd0, in_ready},  32'd0);
      check("prio_cfg_ready_0", {31'd0, cfg_ready}, 32'd0);
      @(posedge clk); #1;
      clr_req = 1'b0;
      busy = 0;
      seen = 1'b0;
      while (clr_busy && busy < 10) begin
         busy++;
         if (in_ready) seen = 1'b1;
         @(posedge clk); #1;
      end
      check("prio_clr_cycles",   busy, 32'd4);
      check("prio_rdy_in_clr",   {31'd0, seen},      32'd0);
      check("prio_in_ready_cfg", {31'd0, in_ready},  32'd0);
      check("prio_cfg_ready",    {31'd0, cfg_ready}, 32'd1);
      for (int i = 5; i <= 12; i++) check($sformatf("prio_clr_mem%0d", i), mem[i], 32'd0);
      check("prio_mem13_before", mem[13], 32'hDEAD000D);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      check("prio_mem13_after", mem[13], 32'h12345678);
      #1;
      check("prio_in_ready_1", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      busy = 0;
      while (!out_valid && busy < 20) begin
         @(posedge clk); #1; busy++;
      end
      check("prio_latency", busy, 32'd7);
      check("prio_y", out_sample, 32'd77);

      // Reset in the middle of a sequence
      do_clear();
      @(negedge clk);
      in_valid = 1'b1; in_ch = 1'b1; in_sample = 32'd500;
      #1;
      busy = 0;
      while (!in_ready && busy < 50) begin
         @(negedge clk); #1; busy++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      check("mrst_out_valid",  {31'd0, out_valid}, 32'd0);
      check("mrst_out_sample", out_sample,         32'd0);
      check("mrst_out_ch",     {31'd0, out_ch},    32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("mrst_no_valid", {31'd0, seen},     32'd0);
      check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
      do_clear();
      run_sample(1'b1, 32'd500, 32'd500, "mrst_pass");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/biquad_engine.md
Name: biquad_engine

Overview:
- Sequencer/datapath that runs one Direct-Form-I biquad section per input sample for two interleaved channels (L/R).
- Coefficients and per-channel delay state live in the 16-entry dual-port RAM directly downstream; this block drives both RAM ports and consumes their registered read data.
- Also owns coefficient loading and state clearing, so the RAM has a single master.

Parameters:
- NBITS, 32, sample/coefficient/RAM word width (matches c_IIR_NBITS).
- FRAC, 30, coefficient fractional bits (Q2.30 signed).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  sample offered
- in_ready  out  1  combinational: state==IDLE && !clr_req && !cfg_we
- in_ch  in  1  channel of offered sample (0=L, 1=R)
- in_sample  in  NBITS  signed input sample
- out_valid  out  1  one-cycle result strobe
- out_ch  out  1  channel of result
- out_sample  out  NBITS  signed filtered sample
- cfg_we  in  1  coefficient write request
- cfg_addr  in  4  RAM address to write
- cfg_data  in  NBITS  write data
- cfg_ready  out  1  combinational: state==IDLE && !clr_req; write happens on cfg_we && cfg_ready
- clr_req  in  1  zero all delay state
- clr_busy  out  1  high during clear sequence
- ram_addr_a, ram_addr_b  out  4  RAM port addresses
- ram_d_a, ram_d_b  out  NBITS  RAM write data
- ram_we_a, ram_we_b  out  1  RAM write enables
- ram_q_a, ram_q_b  in  NBITS  RAM read data, registered, 1-cycle latency

Behaviour:
- Memory map: 0 B0, 1 B1, 2 B2, 3 A1, 4 A2; ch0: 5 X1, 6 X2, 7 Y1, 8 Y2; ch1: 9 X1, 10 X2, 11 Y1, 12 Y2; 13-15 unused. Let S = 5+4*ch.
- Equation: y = B0*x + B1*X1 + B2*X2 - A1*Y1 - A2*Y2.
- Reset: state IDLE; out_valid=0, out_ch=0, out_sample=0, clr_busy=0, ram_we_a/b=0, all internal registers 0. RAM contents are not reset.
- IDLE priority: clr_req > cfg_we > sample.
- cfg accept: port A write of cfg_data to cfg_addr for one cycle; stay IDLE.
- Sample accept (in_valid && in_ready): latch x and ch; begin the 8-cycle sequence, cycle 1 = accept cycle.
  - C1: read A=B0, B=X1.
  - C2: read A=B1, B=X2; acc = q_a*x; save x1=q_b.
  - C3: read A=B2, B=Y1; acc += q_a*x1; save x2=q_b.
  - C4: read A=A1, B=Y2; acc += q_a*x2; save y1=q_b.
  - C5: read A=A2; acc -= q_a*y1; save y2=q_b.
  - C6: acc -= q_a*y2.
  - C7: y = sat(round(acc)); write A: X2<=x1, B: X1<=x.
  - C8: write A: Y2<=y1, B: Y1<=y; out_valid=1, out_sample=y, out_ch=ch; return to IDLE.
- Latency: out_valid 7 cycles after the accept edge. Throughput: 1 sample per 8 cycles, with in_ready high again the cycle after C8.
- Arithmetic: signed NBITS x NBITS products; accumulator 2*NBITS+3 bits. round = (acc + 2^(FRAC-1)) >>> FRAC. Saturate to [-2^(NBITS-1), 2^(NBITS-1)-1].
- Clear: 4 cycles, writing zero to 5,6 / 7,8 / 9,10 / 11,12 on ports A/B. clr_busy is high for those 4 cycles, then IDLE. A clr_req during a sample sequence waits for IDLE.
- cfg_we while not cfg_ready is ignored; the master holds it.
- Reset mid-sequence aborts to IDLE with no out_valid. Channel state may be partially updated, so software issues clr_req afterwards.
- Never writes both ports to the same address in one cycle.

Test Plan:
- Passthrough: B0=0x40000000, others 0, cleared state; x=1000 ch0 -> out_valid 7 cycles after accept, y=1000, out_ch=0.
- Recursive: B0=0x40000000, A1=0xE0000000 (-0.5), others 0; ch0 impulse 1024, then 0, 0 -> outputs 1024, 512, 256.
- Channel isolation: same setup as Recursive; interleave ch0 impulse 1024 with ch1 samples of 0 -> ch1 outputs all 0, ch0 sequence 1024, 512, 256 unaffected.
- Saturation: B0=0x70000000 (1.75), x=0x7FFF0000 -> y=0x7FFFFFFF; x=0x80010000 -> y=0x80000000.
- Priority: clr_req, cfg_we and in_valid all high in IDLE -> 4 clear cycles (addr 5-12 zeroed, clr_busy=1), then the cfg write, then sample accept; in_ready=0 throughout until then.
- Reset mid-sequence: deassert rstn at C4 -> out_valid stays 0, outputs 0, in_ready=1 after release; clr then passthrough test -> correct result.
